// File: rtl/csr_evfifo.sv
// csr_evfifo: event FIFO filled by a hardware producer and drained over the
// CSR bus. Six registers (DATA, POP, LEVEL, STAT, CTRL, DROPS) are decoded
// from csr_a[2:0] when csr_a[13:10] matches csr_addr. irq is a registered
// level interrupt that is high while enabled and the FIFO holds data.
module csr_evfifo #(
  parameter logic [3:0] csr_addr   = 4'h2,
  parameter int         depth_log2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        ev_stb,
  input  logic [31:0] ev_data,
  output logic        irq
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] level_full = (depth_log2 + 1)'(depth);
  localparam logic [depth_log2:0] level_one  = (depth_log2 + 1)'(1);

  logic [31:0]           mem_r [depth];
  logic [depth_log2-1:0] rd_ptr_r;
  logic [depth_log2-1:0] wr_ptr_r;
  logic [depth_log2:0]   level_r;
  logic                  overflow_r;
  logic [15:0]           drops_r;
  logic                  irq_en_r;
  logic [31:0]           csr_do_r;
  logic                  irq_r;

  logic                  sel_s;
  logic [2:0]            idx_s;
  logic                  wr_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  flush_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  drop_s;
  logic [depth_log2:0]   level_nxt_s;
  logic                  overflow_nxt_s;
  logic [15:0]           drops_nxt_s;
  logic [31:0]           rd_data_s;
  logic                  unused_s;

  assign sel_s    = (csr_a[13:10] == csr_addr);
  assign idx_s    = csr_a[2:0];
  assign wr_s     = sel_s & csr_we;
  assign empty_s  = (level_r == '0);
  assign full_s   = (level_r == level_full);
  assign unused_s = ^{csr_a[9:3], csr_di[31:3]};

  // Push/pop/flush arbitration: flush wins, pop frees a slot for a same-cycle push
  always_comb begin
    flush_s = wr_s & (idx_s == 3'd4) & csr_di[1];
    pop_s   = wr_s & (idx_s == 3'd1) & ~empty_s & ~flush_s;
    push_s  = ev_stb & ~flush_s & (~full_s | pop_s);
    drop_s  = ev_stb & ~flush_s & full_s & ~pop_s;
  end

  // Next occupancy, sticky overflow and saturating drop counter
  always_comb begin
    level_nxt_s = level_r;
    if (flush_s) begin
      level_nxt_s = '0;
    end else if (push_s && !pop_s) begin
      level_nxt_s = level_r + level_one;
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - level_one;
    end else begin
      level_nxt_s = level_r;
    end

    overflow_nxt_s = overflow_r;
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (wr_s && (idx_s == 3'd3) && csr_di[2]) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end

    drops_nxt_s = drops_r;
    if (wr_s && (idx_s == 3'd5)) begin
      drops_nxt_s = drop_s ? 16'd1 : 16'd0;
    end else if (drop_s && (drops_r != 16'hFFFF)) begin
      drops_nxt_s = drops_r + 16'd1;
    end else begin
      drops_nxt_s = drops_r;
    end
  end

  // CSR read mux over the state present at the start of the cycle
  always_comb begin
    rd_data_s = 32'd0;
    if (sel_s) begin
      case (idx_s)
        3'd0: rd_data_s = empty_s ? 32'd0 : mem_r[rd_ptr_r];
        3'd2: rd_data_s = {{(31 - depth_log2){1'b0}}, level_r};
        3'd3: rd_data_s = {29'd0, overflow_r, full_s, empty_s};
        3'd4: rd_data_s = {31'd0, irq_en_r};
        3'd5: rd_data_s = {16'd0, drops_r};
        default: rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Control state, pointers and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
      drops_r    <= 16'd0;
      irq_en_r   <= 1'b0;
      csr_do_r   <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      if (flush_s) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
      end else begin
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + 1'b1;
        end
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + 1'b1;
        end
      end
      level_r    <= level_nxt_s;
      overflow_r <= overflow_nxt_s;
      drops_r    <= drops_nxt_s;
      if (wr_s && (idx_s == 3'd4)) begin
        irq_en_r <= csr_di[0];
      end
      csr_do_r   <= rd_data_s;
      irq_r      <= irq_en_r & ~empty_s;
    end
  end

  // Event storage; contents are don't-care until written, so no reset
  always_ff @(posedge sys_clk) begin
    if (push_s && !sys_rst) begin
      mem_r[wr_ptr_r] <= ev_data;
    end
  end

  assign csr_do = csr_do_r;
  assign irq    = irq_r;

endmodule

// File: tb/tb_csr_evfifo.sv
// Testbench for csr_evfifo: directed stimulus pushes expected CSR read data
// and irq levels into queues; a monitor pops and compares them one cycle
// after each read/irq check is issued.
module tb_csr_evfifo;

  localparam logic [3:0] dev = 4'h2;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a   = 14'd0;
  logic        csr_we  = 1'b0;
  logic [31:0] csr_di  = 32'd0;
  logic [31:0] csr_do;
  logic        ev_stb  = 1'b0;
  logic [31:0] ev_data = 32'd0;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic        rd_issue  = 1'b0;
  logic        irq_issue = 1'b0;
  logic        rd_vld    = 1'b0;
  logic        irq_vld   = 1'b0;
  logic [31:0] rd_exp_q [$];
  string       rd_nm_q  [$];
  logic        irq_exp_q [$];
  string       irq_nm_q  [$];

  csr_evfifo #(.csr_addr(dev), .depth_log2(4)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .ev_stb  (ev_stb),
    .ev_data (ev_data),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  always @(posedge sys_clk) begin
    rd_vld  <= rd_issue;
    irq_vld <= irq_issue;
  end

  always @(negedge sys_clk) begin
    logic [31:0] e;
    logic        ei;
    string       n;
    if (rd_vld) begin
      checks++;
      if (rd_exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_queue: read data %h with no expected value", csr_do);
      end else begin
        e = rd_exp_q.pop_front();
        n = rd_nm_q.pop_front();
        if (csr_do !== e) begin
          failures++;
          $display("FAIL %s: csr_do=%h expected %h", n, csr_do, e);
        end
      end
    end
    if (irq_vld) begin
      checks++;
      if (irq_exp_q.size() == 0) begin
        failures++;
        $display("FAIL irq_queue: irq=%b with no expected value", irq);
      end else begin
        ei = irq_exp_q.pop_front();
        n  = irq_nm_q.pop_front();
        if (irq !== ei) begin
          failures++;
          $display("FAIL %s: irq=%b expected %b", n, irq, ei);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cyc(input logic stb, input logic [31:0] data, input logic we,
                     input logic [2:0] idx, input logic [31:0] di);
    ev_stb  = stb;
    ev_data = data;
    csr_we  = we;
    csr_a   = {dev, 7'd0, idx};
    csr_di  = di;
    tick();
    ev_stb  = 1'b0;
    csr_we  = 1'b0;
    csr_a   = 14'd0;
  endtask

  task automatic push(input logic [31:0] d);
    cyc(1'b1, d, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] di);
    cyc(1'b0, 32'd0, 1'b1, idx, di);
  endtask

  task automatic rd_dev(input logic [3:0] d, input logic [2:0] idx,
                        input logic [31:0] exp, input string nm);
    csr_a  = {d, 7'd0, idx};
    csr_we = 1'b0;
    rd_exp_q.push_back(exp);
    rd_nm_q.push_back(nm);
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
    csr_a    = 14'd0;
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string nm);
    rd_dev(dev, idx, exp, nm);
  endtask

  task automatic chk_irq(input logic exp, input string nm);
    irq_exp_q.push_back(exp);
    irq_nm_q.push_back(nm);
    irq_issue = 1'b1;
    tick();
    irq_issue = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    sys_rst = 1'b0;

    // Reset state
    rd(3'd0, 32'd0, "rst_data");
    rd(3'd1, 32'd0, "rst_pop");
    rd(3'd2, 32'd0, "rst_level");
    rd(3'd3, 32'h1, "rst_stat");
    rd(3'd4, 32'd0, "rst_ctrl");
    rd(3'd5, 32'd0, "rst_drops");
    rd(3'd6, 32'd0, "rst_idx6");
    chk_irq(1'b0, "rst_irq");
    rd_dev(4'h3, 3'd3, 32'd0, "unsel_stat");

    // Basic push / pop with interrupt
    push(32'hA); push(32'hB); push(32'hC);
    chk_irq(1'b0, "irq_disabled");
    wr(3'd4, 32'h1);
    rd(3'd2, 32'd3, "abc_level");
    rd(3'd0, 32'hA, "abc_data_a");
    rd(3'd4, 32'h1, "ctrl_irq_en");
    chk_irq(1'b1, "irq_pending");
    wr(3'd1, 32'd0); rd(3'd0, 32'hB, "abc_data_b");
    wr(3'd1, 32'd0); rd(3'd0, 32'hC, "abc_data_c");
    wr(3'd1, 32'd0); rd(3'd0, 32'd0, "abc_data_empty");
    rd(3'd2, 32'd0, "abc_level_empty");
    rd(3'd3, 32'h1, "abc_stat_empty");
    chk_irq(1'b0, "irq_drained");

    // Overflow with pointer wrap
    for (int i = 0; i < 18; i++) push(32'(i));
    rd(3'd2, 32'd16, "ovf_level");
    rd(3'd3, 32'h6, "ovf_stat");
    rd(3'd5, 32'd2, "ovf_drops");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h2, "ovf_stat_clr");
    for (int i = 0; i < 16; i++) begin
      rd(3'd0, 32'(i), $sformatf("wrap_data%0d", i));
      wr(3'd1, 32'd0);
    end
    rd(3'd3, 32'h1, "wrap_stat_empty");

    // Push and pop together while full, then while empty
    for (int i = 0; i < 16; i++) push(32'(100 + i));
    cyc(1'b1, 32'h55, 1'b1, 3'd1, 32'd0);
    rd(3'd2, 32'd16, "fullpp_level");
    rd(3'd5, 32'd2, "fullpp_drops");
    rd(3'd3, 32'h2, "fullpp_stat");
    for (int i = 1; i < 16; i++) begin
      rd(3'd0, 32'(100 + i), $sformatf("fullpp_data%0d", i));
      wr(3'd1, 32'd0);
    end
    rd(3'd0, 32'h55, "fullpp_last");
    wr(3'd1, 32'd0);
    cyc(1'b1, 32'h77, 1'b1, 3'd1, 32'd0);
    rd(3'd2, 32'd1, "emptypp_level");
    rd(3'd0, 32'h77, "emptypp_data");
    wr(3'd1, 32'd0);
    rd(3'd2, 32'd0, "emptypp_drained");

    // Flush racing a push
    for (int i = 0; i < 5; i++) push(32'(200 + i));
    cyc(1'b1, 32'h99, 1'b1, 3'd4, 32'h2);
    rd(3'd2, 32'd0, "flush_level");
    rd(3'd5, 32'd2, "flush_drops");
    rd(3'd3, 32'h1, "flush_stat");
    rd(3'd4, 32'h0, "flush_ctrl");

    // DROPS saturation
    wr(3'd5, 32'd0);
    rd(3'd5, 32'd0, "drops_clr");
    for (int i = 0; i < 16; i++) push(32'(300 + i));
    ev_stb = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    ev_stb = 1'b0;
    rd(3'd5, 32'hFFFE, "drops_fffe");
    rd(3'd3, 32'h6, "drops_stat");
    for (int i = 0; i < 5; i++) push(32'h1234);
    rd(3'd5, 32'hFFFF, "drops_sat");
    wr(3'd5, 32'h0);
    rd(3'd5, 32'd0, "drops_wr_clr");
    cyc(1'b1, 32'h1, 1'b1, 3'd5, 32'd0);
    rd(3'd5, 32'd1, "drops_clr_and_inc");
    cyc(1'b1, 32'h1, 1'b1, 3'd3, 32'h4);
    rd(3'd3, 32'h6, "ovf_clr_and_set");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h2, "ovf_clr_full");
    rd(3'd0, 32'd300, "sat_head");

    // Reset mid-burst
    wr(3'd4, 32'h2);
    rd(3'd2, 32'd0, "pre_rst_flush");
    wr(3'd4, 32'h1);
    for (int i = 0; i < 7; i++) push(32'(400 + i));
    rd(3'd2, 32'd7, "pre_rst_level");
    chk_irq(1'b1, "pre_rst_irq");
    sys_rst = 1'b1;
    cyc(1'b1, 32'hDEAD, 1'b1, 3'd4, 32'h1);
    sys_rst = 1'b0;
    rd(3'd2, 32'd0, "post_rst_level");
    rd(3'd3, 32'h1, "post_rst_stat");
    rd(3'd4, 32'd0, "post_rst_ctrl");
    rd(3'd5, 32'd0, "post_rst_drops");
    chk_irq(1'b0, "post_rst_irq");

    repeat (3) tick();
    checks++;
    if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained: rd=%0d irq=%0d expected 0 0",
               rd_exp_q.size(), irq_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
